// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and helpers for the dual-port SRAM arbiter
//
// Purpose: requester index type sized for the largest supported requester
//          count, the per-port response tag, the port identifiers and a
//          wrapping increment helper used by the round-robin logic.
// Ports:   none (package)
package sram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef logic [IDX_W-1:0] req_idx_t;

  // One tag per macro port: a read is in flight and which requester owns it.
  typedef struct packed {
    logic     vld;
    req_idx_t idx;
  } port_tag_t;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  // (i + 1) mod n for indices already in 0..n-1.
  function automatic req_idx_t wrap_inc(input req_idx_t i, input int n);
    int t;
    t = int'(i) + 1;
    if (t >= n) t = 0;
    return req_idx_t'(t);
  endfunction

endpackage

// File: rtl/sram_dp_arbiter_rr_pick.sv
// rtl/sram_dp_arbiter_rr_pick.sv - round-robin find-first starting at a pointer
//
// Purpose: returns the first set bit of vld scanning ptr, ptr+1, ... mod N.
// Ports:
//   vld    in  N        candidate bits
//   ptr    in  idx      scan start position (0..N-1)
//   found  out 1        at least one candidate set
//   idx    out idx      index of the first candidate in scan order
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] vld,
  input  req_idx_t     ptr,
  output logic         found,
  output req_idx_t     idx
);

  // Rotating a doubled copy right by ptr puts scan position k at bit k.
  logic [2*N-1:0] rotated;
  assign rotated = {vld, vld} >> ptr;

  always_comb begin
    int sum;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && rotated[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        idx   = req_idx_t'(sum);
      end
    end
  end

endmodule

// File: rtl/sram_dp_arbiter.sv
// rtl/sram_dp_arbiter.sv - round-robin arbiter sharing one dual-port SRAM macro
//
// Purpose: grants up to two requesters per cycle (first on rw0, second on rw1),
//          drops the second grant on a same-address conflict involving a write,
//          and routes 1-cycle-latency read data back to the issuing requester.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready/we       per-requester handshake and direction
//   req_addr/req_wdata       packed per-requester address and write data
//   rsp_valid/rsp_rdata      per-requester read response, one cycle after grant
//   rw0_*_in / rw1_*_in      macro controls (ce, we, addr, wd) per port
//   rw0_rd_out / rw1_rd_out  macro read data, valid the cycle after a read
module sram_dp_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BITS       = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BITS-1:0]       req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*BITS-1:0]       rsp_rdata,
  output logic                          rw0_ce_in,
  output logic                          rw0_we_in,
  output logic [ADDR_WIDTH-1:0]         rw0_addr_in,
  output logic [BITS-1:0]               rw0_wd_in,
  input  logic [BITS-1:0]               rw0_rd_out,
  output logic                          rw1_ce_in,
  output logic                          rw1_we_in,
  output logic [ADDR_WIDTH-1:0]         rw1_addr_in,
  output logic [BITS-1:0]               rw1_wd_in,
  input  logic [BITS-1:0]               rw1_rd_out
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("sram_dp_arbiter: NUM_REQ must be in 2..8");
  end

  req_idx_t            ptr;
  logic                found_a, found_b;
  req_idx_t            idx_a, idx_b;
  logic [NUM_REQ-1:0]  onehot_a;
  logic [NUM_REQ-1:0]  cand_b;
  logic                we_a, we_b, hazard;
  logic                grant_a, grant_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [BITS-1:0]     wd_a, wd_b;
  port_tag_t           tag [2];

  rr_pick #(.N(NUM_REQ)) u_pick_a (
    .vld   (req_valid),
    .ptr   (ptr),
    .found (found_a),
    .idx   (idx_a)
  );

  // Second pick excludes A and resumes right after it, which matches
  // continuing the same scan because nothing between ptr and A was valid.
  assign onehot_a = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_a;
  assign cand_b   = req_valid & ~onehot_a;

  rr_pick #(.N(NUM_REQ)) u_pick_b (
    .vld   (cand_b),
    .ptr   (wrap_inc(idx_a, NUM_REQ)),
    .found (found_b),
    .idx   (idx_b)
  );

  assign we_a   = req_we[idx_a];
  assign we_b   = req_we[idx_b];
  assign addr_a = req_addr[idx_a*ADDR_WIDTH +: ADDR_WIDTH];
  assign addr_b = req_addr[idx_b*ADDR_WIDTH +: ADDR_WIDTH];
  assign wd_a   = req_wdata[idx_a*BITS +: BITS];
  assign wd_b   = req_wdata[idx_b*BITS +: BITS];

  // Two reads of one address are harmless; any write makes the pair unsafe.
  assign hazard  = (addr_a == addr_b) && (we_a || we_b);
  assign grant_a = found_a && !rst;
  assign grant_b = found_b && !hazard && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (grant_a && idx_a == req_idx_t'(i)) ||
                     (grant_b && idx_b == req_idx_t'(i));
    end
  end

  assign rw0_ce_in   = grant_a;
  assign rw0_we_in   = grant_a && we_a;
  assign rw0_addr_in = grant_a ? addr_a : '0;
  assign rw0_wd_in   = grant_a ? wd_a   : '0;
  assign rw1_ce_in   = grant_b;
  assign rw1_we_in   = grant_b && we_b;
  assign rw1_addr_in = grant_b ? addr_b : '0;
  assign rw1_wd_in   = grant_b ? wd_b   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      tag[PORT_A] <= '0;
      tag[PORT_B] <= '0;
    end else begin
      tag[PORT_A].vld <= grant_a && !we_a;
      tag[PORT_A].idx <= idx_a;
      tag[PORT_B].vld <= grant_b && !we_b;
      tag[PORT_B].idx <= idx_b;
      if (grant_b)      ptr <= wrap_inc(idx_b, NUM_REQ);
      else if (grant_a) ptr <= wrap_inc(idx_a, NUM_REQ);
    end
  end

  // Responses are suppressed while rst is high so a read caught by reset
  // never surfaces, even in the cycle the reset first appears.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag[PORT_A].vld && tag[PORT_A].idx == req_idx_t'(i)) begin
        rsp_valid[i]            = !rst;
        rsp_rdata[i*BITS +: BITS] = rw0_rd_out;
      end
      if (tag[PORT_B].vld && tag[PORT_B].idx == req_idx_t'(i)) begin
        rsp_valid[i]            = !rst;
        rsp_rdata[i*BITS +: BITS] = rw1_rd_out;
      end
    end
  end

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// tb/tb_sram_dp_arbiter.sv - self-checking bench for sram_dp_arbiter
module tb_sram_dp_arbiter;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*BW-1:0]   req_wdata, rsp_rdata;
  logic              rw0_ce_in, rw0_we_in, rw1_ce_in, rw1_we_in;
  logic [AW-1:0]     rw0_addr_in, rw1_addr_in;
  logic [BW-1:0]     rw0_wd_in, rw1_wd_in;
  logic [BW-1:0]     rw0_rd_out = '0, rw1_rd_out = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_dp_arbiter #(.NUM_REQ(N), .BITS(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rw0_ce_in(rw0_ce_in), .rw0_we_in(rw0_we_in), .rw0_addr_in(rw0_addr_in),
    .rw0_wd_in(rw0_wd_in), .rw0_rd_out(rw0_rd_out),
    .rw1_ce_in(rw1_ce_in), .rw1_we_in(rw1_we_in), .rw1_addr_in(rw1_addr_in),
    .rw1_wd_in(rw1_wd_in), .rw1_rd_out(rw1_rd_out)
  );

  function automatic logic [BW-1:0] init_val(input int a);
    return BW'(a * 257) ^ 16'h5A5A;
  endfunction

  // SRAM macro: registered read data, writes land at the clock edge.
  logic [BW-1:0] sram [256];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 256; a++) sram[a] <= init_val(a);
      mem_init <= 1'b1;
    end else begin
      if (rw0_ce_in && !rw0_we_in) rw0_rd_out <= sram[rw0_addr_in];
      if (rw1_ce_in && !rw1_we_in) rw1_rd_out <= sram[rw1_addr_in];
      if (rw0_ce_in && rw0_we_in)  sram[rw0_addr_in] <= rw0_wd_in;
      if (rw1_ce_in && rw1_we_in)  sram[rw1_addr_in] <= rw1_wd_in;
    end
  end

  // Reference model state.
  logic [BW-1:0] m_mem [256];
  int            m_ptr;
  logic [N-1:0]  m_rv;
  logic [BW-1:0] m_rd [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] a_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [BW-1:0] d_of(input int i);
    return req_wdata[i*BW +: BW];
  endfunction

  task automatic clear_reqs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [BW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*BW +: BW] = d;
  endtask

  // Called just after a falling edge with inputs already applied; checks the
  // cycle, crosses the rising edge, updates the model, returns after the next
  // falling edge.
  task automatic step();
    int ga, gb, j, last;
    logic [N-1:0]  exp_ready, nv;
    logic [BW-1:0] nd [N];
    logic [25:0]   p0, p1;
    logic          ev;
    #1;
    ga = -1; gb = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (req_valid[j]) begin
          if (ga < 0) ga = j;
          else if (gb < 0) gb = j;
        end
      end
    end
    if (gb >= 0 && a_of(gb) == a_of(ga) && (req_we[ga] || req_we[gb])) gb = -1;
    exp_ready = '0;
    if (ga >= 0) exp_ready[ga] = 1'b1;
    if (gb >= 0) exp_ready[gb] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    p0 = (ga >= 0) ? {1'b1, req_we[ga], a_of(ga), d_of(ga)} : '0;
    p1 = (gb >= 0) ? {1'b1, req_we[gb], a_of(gb), d_of(gb)} : '0;
    check("rw0_port", 64'({rw0_ce_in, rw0_we_in, rw0_addr_in, rw0_wd_in}), 64'(p0));
    check("rw1_port", 64'({rw1_ce_in, rw1_we_in, rw1_addr_in, rw1_wd_in}), 64'(p1));
    for (int i = 0; i < N; i++) begin
      ev = m_rv[i] && !rst;
      check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(ev));
      if (ev) check($sformatf("rsp_rdata[%0d]", i), 64'(rsp_rdata[i*BW +: BW]), 64'(m_rd[i]));
    end
    @(posedge clk);
    nv = '0;
    for (int i = 0; i < N; i++) nd[i] = '0;
    if (ga >= 0 && !req_we[ga]) begin nv[ga] = 1'b1; nd[ga] = m_mem[a_of(ga)]; end
    if (gb >= 0 && !req_we[gb]) begin nv[gb] = 1'b1; nd[gb] = m_mem[a_of(gb)]; end
    if (ga >= 0 && req_we[ga]) m_mem[a_of(ga)] = d_of(ga);
    if (gb >= 0 && req_we[gb]) m_mem[a_of(gb)] = d_of(gb);
    last = (gb >= 0) ? gb : ga;
    if (last >= 0) m_ptr = (last + 1) % N;
    if (rst) begin m_ptr = 0; nv = '0; end
    m_rv = nv;
    for (int i = 0; i < N; i++) m_rd[i] = nd[i];
    @(negedge clk);
  endtask

  initial begin
    int cnt [N];
    for (int a = 0; a < 256; a++) m_mem[a] = init_val(a);
    m_ptr = 0; m_rv = '0;
    for (int i = 0; i < N; i++) m_rd[i] = '0;
    clear_reqs();
    rst = 1'b1;
    @(negedge clk);

    // Reset with every requester asking.
    req_valid = '1;
    repeat (3) begin
      #1;
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_ce", 64'({rw0_ce_in, rw1_ce_in}), 64'(0));
      check("rst_rsp", 64'(rsp_valid), 64'(0));
      step();
    end
    rst = 1'b0;
    clear_reqs();

    // Two writes in one cycle, then read them back.
    set_req(0, 1'b1, 8'h10, 16'hBEEF);
    set_req(1, 1'b1, 8'h20, 16'h1234);
    step();
    clear_reqs();
    set_req(2, 1'b0, 8'h10, 16'h0);
    set_req(3, 1'b0, 8'h20, 16'h0);
    step();
    clear_reqs();
    #1;
    check("wr_rd_valid", 64'(rsp_valid), 64'(4'b1100));
    check("wr_rd_data2", 64'(rsp_rdata[2*BW +: BW]), 64'(16'hBEEF));
    check("wr_rd_data3", 64'(rsp_rdata[3*BW +: BW]), 64'(16'h1234));
    step();

    // Write/read hazard on one address.
    set_req(0, 1'b1, 8'h05, 16'hCAFE);
    set_req(1, 1'b0, 8'h05, 16'h0);
    #1;
    check("hazard_ready", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid[0] = 1'b0;
    step();
    clear_reqs();
    #1;
    check("hazard_rsp_data", 64'(rsp_rdata[1*BW +: BW]), 64'(16'hCAFE));
    step();

    // Two reads of one address are both granted.
    set_req(0, 1'b0, 8'h33, 16'h0);
    set_req(1, 1'b0, 8'h33, 16'h0);
    #1;
    check("dual_rd_ready", 64'(req_ready), 64'(4'b0011));
    step();
    clear_reqs();
    #1;
    check("dual_rd_valid", 64'(rsp_valid), 64'(4'b0011));
    step();

    // Fairness: all four requesters pending for 8 cycles.
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, AW'(8'h40 + i), 16'h0);
      cnt[i] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      #1;
      for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
      step();
    end
    for (int i = 0; i < N; i++) check($sformatf("fair_cnt[%0d]", i), 64'(cnt[i]), 64'(4));
    clear_reqs();
    step();

    // Reset catches a read in flight.
    set_req(0, 1'b0, 8'h77, 16'h0);
    step();
    clear_reqs();
    rst = 1'b1;
    #1;
    check("rst_drop_rsp", 64'(rsp_valid), 64'(0));
    step();
    step();
    rst = 1'b0;
    req_valid = '1;
    #1;
    check("post_rst_prio", 64'(req_ready), 64'(4'b0011));
    step();
    clear_reqs();
    step();

    // Randomised traffic with small address range to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_we[i]    = $urandom_range(0, 1) == 1;
        req_addr[i*AW +: AW]  = AW'($urandom_range(0, 7));
        req_wdata[i*BW +: BW] = BW'($urandom);
      end
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    clear_reqs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
